// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM encoding,
// per-register control bundles and the register-match helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [4:0]  REG_ZERO  = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_bubble;
  } pipe_ctrl_t;

  // Field order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble
  localparam pipe_ctrl_t CTRL_IDLE     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam pipe_ctrl_t CTRL_FROZEN   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam pipe_ctrl_t CTRL_BRANCH   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  // ID/EX stays enabled so the cleared control bits are actually captured.
  localparam pipe_ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam pipe_ctrl_t CTRL_NORMAL   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != REG_ZERO) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector; shared with the forwarding unit.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  output logic       load_use
);

  assign load_use = ex_memread & (reg_match(ex_rd, id_rs1) | reg_match(ex_rd, id_rs2));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: FSM for data-memory waits,
// wait timeout, stall-cycle counter and per-register control decode.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_bubble,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WC_W = $clog2(MAX_WAIT + 1);

  state_t          state;
  logic [WC_W-1:0] wait_cnt;
  logic            load_use;
  logic            mem_stall;
  pipe_ctrl_t      ctrl;

  hazard_detect u_hazard_detect (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .ex_rd      (ex_rd),
    .ex_memread (ex_memread),
    .load_use   (load_use)
  );

  assign mem_stall = dmem_req & ~dmem_ready & (state != ERROR);

  always_comb begin
    ctrl = CTRL_IDLE;
    if (!rst_n)
      ctrl = CTRL_IDLE;
    else if (state == ERROR)
      ctrl = CTRL_FROZEN;
    else if (mem_stall)
      ctrl = CTRL_FROZEN;
    else if (branch_taken)
      ctrl = CTRL_BRANCH;
    else if (load_use)
      ctrl = CTRL_LOAD_USE;
    else
      ctrl = CTRL_NORMAL;
  end

  // wait_cnt counts stalled cycles of the outstanding access, including the first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= WC_W'(1);
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WC_W'(MAX_WAIT - 1)) begin
            state <= ERROR;
          end else begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end
        end
        ERROR: begin
          state <= ERROR;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (!ctrl.pc_en && (stall_cycles != {CNT_W{1'b1}}))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

  assign pc_en        = ctrl.pc_en;
  assign ifid_en      = ctrl.ifid_en;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_en      = ctrl.idex_en;
  assign idex_flush   = ctrl.idex_flush;
  assign exmem_en     = ctrl.exmem_en;
  assign memwb_bubble = ctrl.memwb_bubble;
  assign bus_err      = rst_n & (state == ERROR);

endmodule
